add_round_key: RTL and testbench
================================

ADD_ROUND_KEY -- requirements
Module: add_round_key

Interface
REQ-001 SHALL have parameter DATA_LEN, default 128, width of state and key buses; only 128 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid_in  input  1  data_in carries a state block this cycle (driven by MixColumns).
REQ-005 SHALL have port data_in  input  DATA_LEN  state block; bits [127:120] = byte 0 (s0,0), column-major per FIPS-197.
REQ-006 SHALL have port key_load  input  1  single-cycle pulse capturing key_in as the cipher key.
REQ-007 SHALL have port key_in  input  DATA_LEN  AES-128 cipher key, same byte order as data_in.
REQ-008 SHALL have port valid_out  output  1  data_out holds a result this cycle.
REQ-009 SHALL have port data_out  output  DATA_LEN  data_in XOR current round key.
REQ-010 SHALL have port round_out  output  4  round index (0..10) used for the block on data_out (macro-gated, REQ-030).
REQ-011 SHALL have port last_round  output  1  high with valid_out when round_out = 10 (macro-gated, REQ-030).

Function
REQ-012 SHALL produce data_out = data_in XOR round_key and valid_out = 1 exactly one cycle after an accepted valid_in; valid_out = 0 otherwise.
REQ-013 SHALL hold data_out at its last value when valid_out = 0.
REQ-014 SHALL accept valid_in only when key_ready = 1; before first key_load, valid_in is ignored (valid_out stays 0).
REQ-015 On key_load: cipher_key <= key_in, round_key <= key_in, round <= 0, rcon <= 8'h01, key_ready <= 1.
REQ-016 key_load and valid_in in the same cycle: key_load wins; the data block is dropped; no valid_out next cycle.
REQ-017 Each accepted block SHALL use round_key for the current round, then advance round_key to the next round key and round by 1 in the same edge.
REQ-018 Next-key rule: w0..w3 = round_key[127:96]..[31:0]; t = SubWord(RotWord(w3)) XOR {rcon,24'h0}; w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
REQ-019 rcon SHALL advance as xtime: rcon<<1, XOR 8'h1B when bit 7 set (01,02,..,80,1B,36).
REQ-020 Wrap-around: after the block with round = 10 is accepted, round <= 0, round_key <= cipher_key, rcon <= 8'h01 (ready for next encryption, no reload needed).
REQ-021 Back-to-back valid_in every cycle SHALL be sustained at full throughput with no bubbles.
REQ-022 Blocks SHALL be processed strictly in order; no backpressure, no buffering beyond the one output register.

Reset
REQ-023 Reset SHALL asynchronously clear valid_out, data_out, round_out, last_round, key_ready, cipher_key, round_key, round to 0 and set rcon to 8'h01.
REQ-024 Reset mid-encryption SHALL abandon the sequence; key_load is required before any further output.

Configuration
REQ-030 Macro AES_ARK_ROUND_TAG_EN: defined -> round_out and last_round ports present and registered alongside data_out; undefined -> ports absent, round counter kept internal, data behaviour identical.

Structure
REQ-031 Package aes_pkg SHALL hold DATA_LEN default, NUM_ROUNDS = 10, RCON_INIT = 8'h01, RCON_POLY = 8'h1B, and the xtime function.
REQ-032 Sub-module aes_sbox (combinational byte-in/byte-out forward S-box) SHALL be instantiated 4 times for SubWord.

Verification
REQ-040 key_load key 2B7E151628AED2A6ABF7158809CF4F3C, then data_in 3243F6A8885A308D313198A2E0370734 -> next cycle data_out 193DE3BEA0F4E22B9AC68D2AE9F84808, round_out 0.
REQ-041 Same key, 11 consecutive zero blocks -> data_out sequence starts 2B7E1516..., A0FAFE1788542CB123A339392A6C7605, ends D014F9A8C9EE2589E13F0CC8B6630CA6 with last_round = 1 on the 11th only.
REQ-042 12th zero block after REQ-041 -> data_out 2B7E151628AED2A6ABF7158809CF4F3C, round_out 0 (wrap).
REQ-043 valid_in before any key_load, and valid_in coincident with key_load -> valid_out stays 0; following block uses round 0.
REQ-044 Assert reset after 5 rounds -> all outputs 0 immediately; valid_in ignored until key_load; then round 0 key used.
REQ-045 Blocks with one-cycle gaps between them -> round advances only on accepted blocks; results match REQ-041 sequence.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the AddRoundKey stage.
//   AES_DATA_LEN : width of the state and key buses (only 128 is supported)
//   NUM_ROUNDS   : index of the final round (rounds are numbered 0..10)
//   RCON_INIT    : round constant used for the first key expansion step
//   RCON_POLY    : reduction constant for xtime (x^8 + x^4 + x^3 + x + 1)
//   xtime()      : multiply by x in GF(2^8)
package aes_pkg;

  localparam int          AES_DATA_LEN = 128;
  localparam logic [3:0]  NUM_ROUNDS   = 4'd10;
  localparam logic [7:0]  RCON_INIT    = 8'h01;
  localparam logic [7:0]  RCON_POLY    = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
//   in_byte  : input byte
//   out_byte : SubBytes(in_byte)
// The substitution is computed as the multiplicative inverse in GF(2^8)
// (a^254, with 0 mapping to 0) followed by the FIPS-197 affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] dbl;
    dbl = {v, v} << n;
    return dbl[15:8];
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain for a^254: 254 = 240 + 12 + 2
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
  end

  assign out_byte = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;

endmodule

// File: rtl/add_round_key.sv
// AES-128 AddRoundKey stage with an on-the-fly key schedule.
// Each accepted block is XORed with the current round key; the key is then
// advanced to the next round key in the same edge, wrapping back to the
// cipher key after round 10 so the next encryption needs no reload.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   valid_in   : data_in carries a state block
//   data_in    : state block, byte 0 in bits [127:120]
//   key_load   : one-cycle pulse, captures key_in as cipher key
//   key_in     : AES-128 cipher key
//   valid_out  : data_out holds a fresh result
//   data_out   : data_in XOR round key (held while valid_out = 0)
//   round_out  : round index of the block on data_out   (AES_ARK_ROUND_TAG_EN)
//   last_round : high with valid_out on round 10         (AES_ARK_ROUND_TAG_EN)
// Build option: define AES_ARK_ROUND_TAG_EN to expose round_out/last_round.
module add_round_key
  import aes_pkg::*;
#(
  parameter int DATA_LEN = AES_DATA_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                key_load,
  input  logic [DATA_LEN-1:0] key_in,
  output logic                valid_out,
  output logic [DATA_LEN-1:0] data_out
`ifdef AES_ARK_ROUND_TAG_EN
  ,
  output logic [3:0]          round_out,
  output logic                last_round
`endif
);

  logic [DATA_LEN-1:0] cipher_key;
  logic [DATA_LEN-1:0] round_key;
  logic [DATA_LEN-1:0] next_key;
  logic [3:0]          round;
  logic [7:0]          rcon;
  logic                key_ready;
  logic                accept;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, t;
  logic [31:0] n0, n1, n2, n3;

  // key_load takes priority: a block arriving with it is dropped
  assign accept = valid_in & key_ready & ~key_load;

  assign w0     = round_key[127:96];
  assign w1     = round_key[95:64];
  assign w2     = round_key[63:32];
  assign w3     = round_key[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_w3[8*g +: 8]),
      .out_byte (sub_w3[8*g +: 8])
    );
  end

  assign t  = sub_w3 ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      key_ready  <= 1'b0;
      cipher_key <= '0;
      round_key  <= '0;
      round      <= 4'd0;
      rcon       <= RCON_INIT;
    end else begin
      valid_out <= 1'b0;
      if (key_load) begin
        cipher_key <= key_in;
        round_key  <= key_in;
        round      <= 4'd0;
        rcon       <= RCON_INIT;
        key_ready  <= 1'b1;
      end else if (accept) begin
        valid_out <= 1'b1;
        data_out  <= data_in ^ round_key;
        if (round == NUM_ROUNDS) begin
          round     <= 4'd0;
          round_key <= cipher_key;
          rcon      <= RCON_INIT;
        end else begin
          round     <= round + 4'd1;
          round_key <= next_key;
          rcon      <= xtime(rcon);
        end
      end
    end
  end

`ifdef AES_ARK_ROUND_TAG_EN
  // Tags update only with data_out, so they describe the block being held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_out  <= 4'd0;
      last_round <= 1'b0;
    end else begin
      last_round <= 1'b0;
      if (accept) begin
        round_out  <= round;
        last_round <= (round == NUM_ROUNDS);
      end
    end
  end
`endif

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key: a FIPS-197 key-expansion model
// (table S-box built by inverse search) drives a per-cycle comparison,
// and known-answer vectors pin the model.
module tb_add_round_key;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic [127:0] data_in = '0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         valid_out;
  logic [127:0] data_out;
`ifdef AES_ARK_ROUND_TAG_EN
  logic [3:0]   round_out;
  logic         last_round;
`endif

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] PT  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] CT0 = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
  localparam logic [127:0] RK1 = 128'hA0FAFE1788542CB123A339392A6C7605;
  localparam logic [127:0] RK10 = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;

  add_round_key #(.DATA_LEN(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .key_load  (key_load),
    .key_in    (key_in),
    .valid_out (valid_out),
    .data_out  (data_out)
`ifdef AES_ARK_ROUND_TAG_EN
    ,
    .round_out (round_out),
    .last_round(last_round)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]   sb [256];
  logic [127:0] rk [11];
  logic [7:0]   rcon_tbl [10];
  logic         m_ready;
  int           m_round;
  logic         e_valid;
  logic [127:0] e_data;
  int           e_round;
  logic         e_last;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int r = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11B;
    end
    return r[7:0];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] v);
    logic [7:0] inv = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    if (v != 0)
      for (int y = 1; y < 256; y++)
        if (gmul(v, y[7:0]) == 8'h01) inv = y[7:0];
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rcon_tbl[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  initial begin
    rcon_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(i[7:0]);
    for (int r = 0; r < 11; r++) rk[r] = '0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready = 1'b0; m_round = 0;
      e_valid = 1'b0; e_data = '0; e_round = 0; e_last = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
      if (key_load) begin
        expand(key_in);
        m_ready = 1'b1;
        m_round = 0;
      end else if (valid_in && m_ready) begin
        e_valid = 1'b1;
        e_data  = data_in ^ rk[m_round];
        e_round = m_round;
        e_last  = (m_round == 10);
        m_round = (m_round == 10) ? 0 : m_round + 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_valid_out", {127'b0, valid_out}, {127'b0, e_valid});
    chk("model_data_out", data_out, e_data);
`ifdef AES_ARK_ROUND_TAG_EN
    chk("model_round_out", {124'b0, round_out}, e_round[127:0]);
    chk("model_last_round", {127'b0, last_round}, {127'b0, e_last});
`endif
  end

  task automatic step(input logic v, input logic [127:0] d, input logic kl, input logic [127:0] k);
    @(negedge clk);
    valid_in = v; data_in = d; key_load = kl; key_in = k;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid_out", {127'b0, valid_out}, 128'd0);
    chk("reset_data_out", data_out, 128'd0);
    @(negedge clk);
    reset = 1'b0;

    // no key yet: block ignored
    step(1'b1, rnd128(), 1'b0, '0);
    chk("nokey_valid_out", {127'b0, valid_out}, 128'd0);

    // FIPS-197 known answer
    step(1'b0, '0, 1'b1, KEY);
    step(1'b1, PT, 1'b0, '0);
    chk("kat_valid", {127'b0, valid_out}, 128'd1);
    chk("kat_data", data_out, CT0);
`ifdef AES_ARK_ROUND_TAG_EN
    chk("kat_round", {124'b0, round_out}, 128'd0);
`endif

    // key_load coincident with valid_in: block dropped
    step(1'b1, rnd128(), 1'b1, KEY);
    chk("coincident_valid", {127'b0, valid_out}, 128'd0);

    // 11 back-to-back zero blocks, then the wrap
    for (int i = 0; i < 11; i++) begin
      step(1'b1, '0, 1'b0, '0);
      if (i == 0)  chk("b2b_rk0", data_out, KEY);
      if (i == 1)  chk("b2b_rk1", data_out, RK1);
      if (i == 10) chk("b2b_rk10", data_out, RK10);
`ifdef AES_ARK_ROUND_TAG_EN
      chk("b2b_last", {127'b0, last_round}, {127'b0, (i == 10)});
`endif
    end
    step(1'b1, '0, 1'b0, '0);
    chk("wrap_rk0", data_out, KEY);
    step(1'b0, '0, 1'b0, '0);
    chk("hold_data", data_out, KEY);

    // gapped blocks
    step(1'b0, '0, 1'b1, KEY);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, '0, 1'b0, '0);
      if (i == 1)  chk("gap_rk1", data_out, RK1);
      if (i == 10) chk("gap_rk10", data_out, RK10);
      step(1'b0, rnd128(), 1'b0, '0);
    end

    // reset after 5 rounds
    step(1'b0, '0, 1'b1, KEY);
    for (int i = 0; i < 5; i++) step(1'b1, rnd128(), 1'b0, '0);
    reset = 1'b1;
    #1;
    chk("midreset_valid", {127'b0, valid_out}, 128'd0);
    chk("midreset_data", data_out, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, rnd128(), 1'b0, '0);
    chk("postreset_ignored", {127'b0, valid_out}, 128'd0);
    step(1'b0, '0, 1'b1, KEY);
    step(1'b1, PT, 1'b0, '0);
    chk("postreset_kat", data_out, CT0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 70, rnd128(),
           $urandom_range(0, 99) < 3, rnd128());
    end
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
